// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: handshake and data bundle between the decode stage and the immediate extender
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  imm_in;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] imm_out;
    logic [2:0]       count;

    modport master (
        output flush, in_valid, imm_in, mode, out_ready,
        input  in_ready, out_valid, imm_out, count
    );

    modport slave (
        input  flush, in_valid, imm_in, mode, out_ready,
        output in_ready, out_valid, imm_out, count
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: elastic STAGES-deep immediate extender (zero/sign/upper/branch); branch shift enabled by IMM_EXT_BRANCH_EN
module imm_extend_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_extend_pipe_if.slave  bus
);
    logic [OUT_W-1:0]  w_sext;
    logic [OUT_W-1:0]  w_zext;
    logic [OUT_W-1:0]  w_upper;
    logic [OUT_W-1:0]  w_ext;
    logic [STAGES-1:0] w_adv;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [STAGES-1:0] r_valid;
    logic [OUT_W-1:0]  r_data [STAGES];
    logic [2:0]        r_count;

    assign w_sext  = {{(OUT_W-IN_W){bus.imm_in[IN_W-1]}}, bus.imm_in};
    assign w_zext  = {{(OUT_W-IN_W){1'b0}}, bus.imm_in};
    assign w_upper = {bus.imm_in, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
    assign w_ext = (bus.mode == 2'b11) ? {w_sext[OUT_W-3:0], 2'b00} :
                   (bus.mode == 2'b10) ? w_upper :
                   bus.mode[0]         ? w_sext : w_zext;
`else
    assign w_ext = (bus.mode == 2'b10) ? w_upper :
                   bus.mode[0]         ? w_sext : w_zext;
`endif

    // advance chain, resolved from the output end so bubbles collapse
    always_comb begin
        w_adv[STAGES-1] = !r_valid[STAGES-1] || bus.out_ready;
        for (int k = STAGES - 2; k >= 0; k--) w_adv[k] = !r_valid[k] || w_adv[k+1];
    end

    assign w_in_xfer     = bus.in_valid && w_adv[0];
    assign w_out_xfer    = r_valid[STAGES-1] && bus.out_ready;
    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.imm_out   = r_data[STAGES-1];
    assign bus.count     = r_count;

    // stage registers and occupancy; flush drops everything, including the offered input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_count <= '0;
            for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
        end else if (bus.flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_count <= r_count + 3'(w_in_xfer) - 3'(w_out_xfer);
            if (w_adv[0]) begin
                r_valid[0] <= bus.in_valid;
                r_data[0]  <= w_ext;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    r_data[k]  <= r_data[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: vector table, handshake corner sequences and randomized run against a queue model
module tb_imm_extend_pipe;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] m);
        longint u = longint'(imm);
        longint s = (imm >= 16'h8000) ? u - 65536 : u;
        case (m)
            2'd0: return 32'(u);
            2'd1: return 32'(s);
            2'd2: return 32'(u * 65536);
`ifdef IMM_EXT_BRANCH_EN
            default: return 32'(s * 4);
`else
            default: return 32'(s);
`endif
        endcase
    endfunction

    task automatic idle();
        bus.flush = 0; bus.in_valid = 0; bus.imm_in = '0; bus.mode = '0; bus.out_ready = 1;
    endtask

    // one entry into an empty pipe with out_ready high; out_valid must rise exactly S edges later
    task automatic apply_vec(input string name, input logic [15:0] imm, input logic [1:0] m, input logic [31:0] exp);
        @(negedge clk);
        bus.in_valid = 1; bus.imm_in = imm; bus.mode = m; bus.out_ready = 1;
        #1 chk({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
        for (int c = 1; c < S; c++) begin
            @(negedge clk);
            bus.in_valid = 0;
            #1 chk({name, " early out_valid"}, 32'(bus.out_valid), 32'd0);
        end
        @(negedge clk);
        bus.in_valid = 0;
        #1 chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, " data"}, bus.imm_out, exp);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        logic [31:0] q[$];
        int seen;
        tbl[0] = '{16'h8001, 2'b01, 32'hFFFF8001};
        tbl[1] = '{16'h8001, 2'b00, 32'h00008001};
        tbl[2] = '{16'h1234, 2'b10, 32'h12340000};
`ifdef IMM_EXT_BRANCH_EN
        tbl[3] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};
        tbl[4] = '{16'h0004, 2'b11, 32'h00000010};
`else
        tbl[3] = '{16'hFFFF, 2'b11, 32'hFFFFFFFF};
        tbl[4] = '{16'h0004, 2'b11, 32'h00000004};
`endif
        tbl[5] = '{16'h7FFF, 2'b01, 32'h00007FFF};
        tbl[6] = '{16'hFFFF, 2'b10, 32'hFFFF0000};
        tbl[7] = '{16'hFFFF, 2'b00, 32'h0000FFFF};

        idle();
        #3;
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset imm_out", bus.imm_out, 32'd0);
        chk("reset count", 32'(bus.count), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        #14 rst_n = 1;

        foreach (tbl[i]) apply_vec($sformatf("vec%0d", i), tbl[i].imm, tbl[i].mode, tbl[i].exp);

        // backpressure: three entries offered while downstream stalls for four cycles
        @(negedge clk);
        bus.out_ready = 0; bus.mode = 2'b00;
        for (int v = 1; v <= 3; v++) begin
            bus.in_valid = 1; bus.imm_in = 16'(v);
            #1;
            if (v == 3) begin
                chk("bp in_ready full", 32'(bus.in_ready), 32'd0);
                chk("bp count full", 32'(bus.count), 32'(S));
            end
            @(negedge clk);
        end
        #1 chk("bp still full", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.out_ready = 1;
        #1 chk("bp in_ready on out_ready", 32'(bus.in_ready), 32'd1);
        for (int v = 1; v <= 3; v++) begin
            chk($sformatf("bp out%0d valid", v), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp out%0d data", v), bus.imm_out, 32'(v));
            @(negedge clk);
            bus.in_valid = 0;
            #1;
        end
        chk("bp drained count", 32'(bus.count), 32'd0);
        chk("bp drained valid", 32'(bus.out_valid), 32'd0);

        // flush with two entries held and a new entry offered
        bus.out_ready = 0; bus.in_valid = 1; bus.imm_in = 16'h00AA;
        @(negedge clk);
        bus.imm_in = 16'h00BB;
        @(negedge clk);
        bus.flush = 1; bus.imm_in = 16'h0DEA; bus.out_ready = 0;
        #1 chk("flush pre count", 32'(bus.count), 32'd2);
        @(negedge clk);
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        #1 chk("flush count", 32'(bus.count), 32'd0);
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 if (bus.out_valid) seen++;
        end
        chk("flush nothing emerges", 32'(seen), 32'd0);

        // asynchronous reset with the pipe full
        bus.out_ready = 0; bus.in_valid = 1; bus.imm_in = 16'h0011;
        @(negedge clk);
        bus.imm_in = 16'h0022;
        @(negedge clk);
        bus.in_valid = 0;
        #2 chk("arst pre count", 32'(bus.count), 32'd2);
        rst_n = 0;
        #1 chk("arst out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst count", 32'(bus.count), 32'd0);
        chk("arst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1;
        bus.out_ready = 1;
        apply_vec("after reset", 16'h8001, 2'b01, 32'hFFFF8001);

        // randomized traffic against an ordered queue of expected results
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 49) == 0);
            bus.mode      = 2'($urandom_range(0, 3));
            bus.imm_in    = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h8000 : 16'h7FFF) : 16'($urandom);
            #1;
            chk("rnd count", 32'(bus.count), 32'(q.size()));
            chk("rnd in_ready", 32'(bus.in_ready), 32'((q.size() < S) || bus.out_ready));
            if (bus.out_valid) begin
                if (q.size() == 0) chk("rnd spurious out_valid", 32'd1, 32'd0);
                else chk("rnd data", bus.imm_out, q[0]);
            end
            if (bus.flush) q.delete();
            else begin
                if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
                if (bus.in_valid && bus.in_ready) q.push_back(model(bus.imm_in, bus.mode));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
